matrix_mult_seq: RTL and testbench
==================================

Name: matrix_mult_seq

Overview:
- Sequential responder for the matrix-multiply vin/vout handshake: captures flattened A and B on a one-cycle vin pulse and computes C = A x B with a single multiply-accumulate unit, one product per cycle.
- Pulses vout for one cycle when the packed C is valid.
- Drop-in area-reduced alternative to the fully parallel multiplier, with identical matrix packing, so existing benches and CSV vectors drive it unchanged.

Parameters:
- dsize, 8, element width in bits (unsigned)
- rowsA, 3, rows of A
- colsA, 1, columns of A; must equal rowsB
- rowsB, 1, rows of B
- colsB, 3, columns of B

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- vin  input  1  one-cycle request pulse; A and B are sampled on the same edge
- A  input  rowsA*colsA*dsize  matrix A, row-major; element i occupies bits [(i+1)*dsize-1 -: dsize], with i = r*colsA + c
- B  input  rowsB*colsB*dsize  matrix B, same packing with colsB
- vout  output  1  one-cycle pulse; C is valid and stable from this cycle on
- busy  output  1  high from the capture edge until vout's cycle ends
- C  output  rowsA*colsB*dsize  result, same packing; element index r*colsB + c

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; vout=0, busy=0, C=0
  - internal A/B copies, shadow result, accumulator and indices all 0
  - An in-flight computation is discarded. The first vin after rst rises is accepted normally.
- States: IDLE, MAC, DONE.
- IDLE:
  - On an edge with vin=1, register A and B internally, clear indices i=j=k=0, set busy=1, go to MAC.
  - vin=0 stays in IDLE.
- MAC, one product per edge:
  - prod = Areg[i][k] * Breg[k][j], 2*dsize bits, unsigned
  - acc_next = (k==0 ? 0 : acc) + prod; accumulator is 2*dsize+clog2(colsA+1) bits, so it never wraps internally
  - When k==colsA-1: write acc_next[dsize-1:0] into shadow element i*colsB+j (result is mod 2^dsize), reset k to 0, advance j; when j wraps, advance i. Otherwise increment k.
  - On the edge that writes the final element (i=rowsA-1, j=colsB-1), copy the completed shadow into C, set vout=1, and go to DONE.
- DONE (one cycle): vout=1, busy=1. On the next edge vout=0, busy=0, and the state returns to IDLE unconditionally.
- Latency:
  - N = rowsA*colsB*colsA MAC edges.
  - If vin is sampled at edge E0, vout and the new C appear after edge EN.
  - Default parameters give N=9; the next vin is accepted at E(N+2) at the earliest.
- C holds its previous value throughout a computation and changes only on the vout edge. Partial results are never visible.
- vin is ignored in MAC and DONE; A and B changes after capture have no effect.
- colsA=1 is legal: every MAC cycle writes one element.

Test Plan:
- Default 3x1x3: A={1,2,3}, B={4,5,6}, vin pulse -> after 9 MAC edges, one-cycle vout with C=0x120F0C0C0A08060504 (elements 4,5,6,8,10,12,12,15,18, element 0 at LSB); busy high for 10 cycles.
- Wrap: A={0x10,0x02,0xFF}, B={0x10,0x01,0x02} -> C elements {0x00,0x10,0x20,0x20,0x02,0x04,0xF0,0xFF,0xFE}.
- rowsA=colsA=rowsB=colsB=2: A={1,2,3,4}, B={5,6,7,8} -> C={19,22,43,50}; vout after 8 MAC edges; all-0xFF inputs give element 0xFE01+0xFE01 truncated = 0x02.
- vin re-pulsed with different A/B during MAC and during DONE -> ignored; C equals the first request's result, exactly one vout pulse.
- rst driven low 4 cycles after vin -> vout, busy and C clear immediately; no vout follows. A fresh request after rst rises returns the correct result.
- Back-to-back: second vin issued in the first IDLE cycle after DONE with new data -> second result correct; C stays stable at the first result until the second vout.

Source files
------------

// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential matrix multiplier C = A x B using one
// multiply-accumulate unit, one product per clock.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-low reset
//   vin  - one-cycle request pulse; A and B are sampled on the same edge
//   A    - rowsA x colsA matrix, row-major, element 0 at the LSB
//   B    - rowsB x colsB matrix, same packing
//   vout - one-cycle pulse when C holds the new result
//   busy - high from the capture edge until the end of the vout cycle
//   C    - rowsA x colsB result, same packing, elements truncated to dsize bits
module matrix_mult_seq #(
    parameter int dsize = 8,
    parameter int rowsA = 3,
    parameter int colsA = 1,
    parameter int rowsB = 1,
    parameter int colsB = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vin,
    input  logic [rowsA*colsA*dsize-1:0] A,
    input  logic [rowsB*colsB*dsize-1:0] B,
    output logic                         vout,
    output logic                         busy,
    output logic [rowsA*colsB*dsize-1:0] C
);

    localparam int IW = (rowsA > 1) ? $clog2(rowsA) : 1;
    localparam int JW = (colsB > 1) ? $clog2(colsB) : 1;
    localparam int KW = (colsA > 1) ? $clog2(colsA) : 1;
    localparam int PW = 2 * dsize;
    // Wide enough to sum colsA full-width products without wrapping.
    localparam int AW = 2 * dsize + $clog2(colsA + 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [dsize-1:0] a_mem       [rowsA][colsA];
    logic [dsize-1:0] b_mem       [rowsB][colsB];
    logic [dsize-1:0] shadow      [rowsA][colsB];
    logic [dsize-1:0] shadow_next [rowsA][colsB];

    logic [rowsA*colsB*dsize-1:0] c_q;
    logic [rowsA*colsB*dsize-1:0] c_next_flat;

    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [KW-1:0] k;
    logic [PW-1:0] prod;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;

    logic k_last, j_last, i_last;
    logic elem_done, final_elem;

    // ---------------------------------------------------------------
    // MAC datapath and result assembly
    // ---------------------------------------------------------------
    always_comb begin
        prod       = PW'(a_mem[i][k]) * PW'(b_mem[k][j]);
        acc_next   = ((k == '0) ? '0 : acc) + AW'(prod);
        k_last     = (k == KW'(colsA - 1));
        j_last     = (j == JW'(colsB - 1));
        i_last     = (i == IW'(rowsA - 1));
        elem_done  = (state == MAC) && k_last;
        final_elem = elem_done && j_last && i_last;

        shadow_next = shadow;
        if (elem_done) begin
            shadow_next[i][j] = acc_next[dsize-1:0];
        end

        // Flattened view including the element written this cycle, so the
        // final element reaches C on the same edge that produces it.
        c_next_flat = '0;
        for (int unsigned r = 0; r < rowsA; r++) begin
            for (int unsigned c = 0; c < colsB; c++) begin
                c_next_flat[(r*colsB+c)*dsize +: dsize] = shadow_next[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < rowsA; r++) begin
                for (int unsigned c = 0; c < colsA; c++) begin
                    a_mem[r][c] <= '0;
                end
                for (int unsigned c = 0; c < colsB; c++) begin
                    shadow[r][c] <= '0;
                end
            end
            for (int unsigned r = 0; r < rowsB; r++) begin
                for (int unsigned c = 0; c < colsB; c++) begin
                    b_mem[r][c] <= '0;
                end
            end
            c_q <= '0;
            acc <= '0;
            i   <= '0;
            j   <= '0;
            k   <= '0;
        end else begin
            if (state == IDLE && vin) begin
                for (int unsigned r = 0; r < rowsA; r++) begin
                    for (int unsigned c = 0; c < colsA; c++) begin
                        a_mem[r][c] <= A[(r*colsA+c)*dsize +: dsize];
                    end
                end
                for (int unsigned r = 0; r < rowsB; r++) begin
                    for (int unsigned c = 0; c < colsB; c++) begin
                        b_mem[r][c] <= B[(r*colsB+c)*dsize +: dsize];
                    end
                end
                i <= '0;
                j <= '0;
                k <= '0;
            end else if (state == MAC) begin
                acc    <= acc_next;
                shadow <= shadow_next;
                if (k_last) begin
                    k <= '0;
                    if (j_last) begin
                        j <= '0;
                        i <= i_last ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end else begin
                    k <= k + 1'b1;
                end
                if (final_elem) begin
                    c_q <= c_next_flat;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vin) state_next = MAC;
            MAC:     if (final_elem) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        vout = (state == DONE);
        busy = (state != IDLE);
        C    = c_q;
    end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Directed bench for matrix_mult_seq: a default 3x1x3 instance and a 2x2x2
// instance, with hand-computed expected results.
module tb_matrix_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        vin1 = 1'b0;
    logic [23:0] a1 = '0;
    logic [23:0] b1 = '0;
    logic        vout1, busy1;
    logic [71:0] c1;

    logic        vin2 = 1'b0;
    logic [31:0] a2 = '0;
    logic [31:0] b2 = '0;
    logic        vout2, busy2;
    logic [31:0] c2;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [71:0] C_DEF  = 72'h120F0C0C0A08060504;
    localparam logic [71:0] C_WRAP = 72'hFEFFF0040220201000;
    localparam logic [31:0] C_2X2  = 32'h322B1613;
    localparam logic [31:0] C_FF   = 32'h02020202;

    always #5 clk = ~clk;

    matrix_mult_seq #(
        .dsize(8), .rowsA(3), .colsA(1), .rowsB(1), .colsB(3)
    ) dut1 (
        .clk(clk), .rst(rst), .vin(vin1), .A(a1), .B(b1),
        .vout(vout1), .busy(busy1), .C(c1)
    );

    matrix_mult_seq #(
        .dsize(8), .rowsA(2), .colsA(2), .rowsB(2), .colsB(2)
    ) dut2 (
        .clk(clk), .rst(rst), .vin(vin2), .A(a2), .B(b2),
        .vout(vout2), .busy(busy2), .C(c2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full request on dut1 (9 MAC edges), checking every cycle.
    task automatic run1(input string tag, input logic [23:0] a, input logic [23:0] b,
                        input logic [71:0] exp_c, input logic [71:0] old_c);
        a1 = a; b1 = b; vin1 = 1'b1;
        tick();
        vin1 = 1'b0;
        check({tag, " busy after capture"}, busy1, 1'b1);
        check({tag, " vout after capture"}, vout1, 1'b0);
        for (int n = 0; n < 8; n++) begin
            tick();
            check({tag, " vout during mac"}, vout1, 1'b0);
            check({tag, " busy during mac"}, busy1, 1'b1);
            check({tag, " C held during mac"}, c1, old_c);
        end
        tick();
        check({tag, " vout pulse"}, vout1, 1'b1);
        check({tag, " busy in done"}, busy1, 1'b1);
        check({tag, " C result"}, c1, exp_c);
        tick();
        check({tag, " vout cleared"}, vout1, 1'b0);
        check({tag, " busy cleared"}, busy1, 1'b0);
        check({tag, " C stable"}, c1, exp_c);
    endtask

    // Full request on dut2 (8 MAC edges).
    task automatic run2(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_c, input logic [31:0] old_c);
        a2 = a; b2 = b; vin2 = 1'b1;
        tick();
        vin2 = 1'b0;
        check({tag, " busy after capture"}, busy2, 1'b1);
        for (int n = 0; n < 7; n++) begin
            tick();
            check({tag, " vout during mac"}, vout2, 1'b0);
            check({tag, " C held during mac"}, c2, old_c);
        end
        tick();
        check({tag, " vout pulse"}, vout2, 1'b1);
        check({tag, " C result"}, c2, exp_c);
        tick();
        check({tag, " vout cleared"}, vout2, 1'b0);
        check({tag, " busy cleared"}, busy2, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset vout1", vout1, 1'b0);
        check("reset busy1", busy1, 1'b0);
        check("reset C1", c1, 72'h0);
        check("reset busy2", busy2, 1'b0);
        check("reset C2", c2, 32'h0);
        rst = 1'b1;
        tick();

        // Default request, then a back-to-back wrapping request issued in
        // the first IDLE cycle after DONE
        run1("default", {8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, C_DEF, 72'h0);
        run1("wrap", {8'hFF, 8'h02, 8'h10}, {8'h02, 8'h01, 8'h10}, C_WRAP, C_DEF);

        // vin re-pulsed during MAC and during DONE with other data
        a1 = {8'd3, 8'd2, 8'd1}; b1 = {8'd6, 8'd5, 8'd4}; vin1 = 1'b1;
        tick();                              // E0 capture
        vin1 = 1'b0; a1 = 24'hAAAAAA; b1 = 24'h555555;
        tick();                              // E1
        tick();                              // E2
        vin1 = 1'b1; a1 = 24'h0F0F0F; b1 = 24'h070707;
        tick();                              // E3, vin in MAC
        vin1 = 1'b0;
        check("ignore C held", c1, C_WRAP);
        for (int n = 0; n < 5; n++) begin   // E4..E8
            tick();
            check("ignore no early vout", vout1, 1'b0);
        end
        tick();                              // E9
        check("ignore vout pulse", vout1, 1'b1);
        check("ignore C result", c1, C_DEF);
        vin1 = 1'b1; a1 = 24'h123456; b1 = 24'h654321;
        tick();                              // E10, vin in DONE
        vin1 = 1'b0;
        check("ignore vout cleared", vout1, 1'b0);
        check("ignore busy cleared", busy1, 1'b0);
        tick();
        check("ignore no restart busy", busy1, 1'b0);
        check("ignore no second vout", vout1, 1'b0);
        check("ignore C stable", c1, C_DEF);

        // Reset in the middle of a computation
        a1 = {8'hFF, 8'h02, 8'h10}; b1 = {8'h02, 8'h01, 8'h10}; vin1 = 1'b1;
        tick();
        vin1 = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        check("midrst vout", vout1, 1'b0);
        check("midrst busy", busy1, 1'b0);
        check("midrst C", c1, 72'h0);
        repeat (2) tick();
        rst = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            check("midrst no vout after", vout1, 1'b0);
        end
        check("midrst busy idle", busy1, 1'b0);
        run1("after rst", {8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, C_DEF, 72'h0);

        // 2x2x2 instance
        run2("2x2", {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, C_2X2, 32'h0);
        run2("2x2 ff", 32'hFFFFFFFF, 32'hFFFFFFFF, C_FF, C_2X2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
